mcpu_mem_ctrl: RTL and testbench
================================

// Module: mcpu_mem_ctrl
// PURPOSE
//  Memory controller/arbiter for the 8-bit minimal CPU core. Owns the 64x8 program/data RAM.
//  Shares the RAM between the CPU and a host port (SPI/debug loader), CPU stalled via clock enable.
//  Provides halt, single-step and run control so the host can load programs and inspect memory.
// PARAMETERS
//  AW      6    address width (RAM depth 2**AW)
//  DW      8    data width
//  CNT_W   16   width of stall counter
// PORTS
//  clk         in   1     clock
//  rst         in   1     synchronous reset, active-low
//  cpu_addr    in   AW    CPU address (valid every cycle)
//  cpu_wdata   in   DW    CPU write data
//  cpu_rd      in   1     CPU read this cycle (sync strobe, derived by wrapper)
//  cpu_wr      in   1     CPU write this cycle
//  cpu_rdata   out  DW    RAM[cpu_addr], combinational
//  cpu_ce      out  1     CPU clock enable (registered)
//  host_req    in   1     host access request, held until host_ack
//  host_we     in   1     1=write, 0=read
//  host_addr   in   AW    host address
//  host_wdata  in   DW    host write data
//  host_rdata  out  DW    read data, valid with host_ack
//  host_ack    out  1     one-cycle completion pulse
//  halt_req    in   1     level: 1 = stop CPU
//  step        in   1     pulse: one CPU cycle while halted
//  halted      out  1     CPU frozen and no host access pending
//  stall_cnt   out  CNT_W cycles cpu_ce=0 while not halted, saturating
// BEHAVIOUR
//  Reset (rst=0): state=HALTED, cpu_ce=0, host_ack=0, host_rdata=0, halted=1, stall_cnt=0;
//    RAM contents not cleared.
//  FSM states: RUN, HOST, HALTED, STEP. Priority: host_req > halt_req > step.
//  RUN: cpu_ce=1; CPU write commits RAM[cpu_addr]<=cpu_wdata at posedge iff cpu_wr & cpu_ce.
//    host_req -> HOST; else halt_req -> HALTED.
//  HOST: cpu_ce=0; access done in first HOST cycle: write commits / host_rdata registered;
//    host_ack=1 that cycle. Next: host_req_new(held) is ignored until ack deasserted one cycle
//    (host must drop req after ack); then halt_req ? HALTED : RUN (returns to origin rule below).
//  Latency: host_req high at edge n -> cpu_ce=0 and access at cycle n+1, ack at n+1, CPU
//    resumes (cpu_ce=1) at n+2 if not halting. CPU state is frozen, so no instruction is lost.
//  HALTED: cpu_ce=0, halted=1 unless host_req. host_req -> HOST (returns to HALTED);
//    step & ~host_req -> STEP; ~halt_req -> RUN.
//  STEP: cpu_ce=1 for exactly one cycle, then HALTED. step during STEP ignored.
//  Simultaneous CPU write and host write same address impossible (cpu_ce=0 during HOST).
//  stall_cnt increments each cycle in HOST entered from RUN; saturates at 2**CNT_W-1.
//  Address wrap: addresses are AW bits, no out-of-range case.
//  Reset mid-HOST: access aborted if reset precedes the edge; no ack is issued.
// CONFIGURATION
//  MCPU_WATCHPOINT_EN defined: extra ports wp_en(in 1), wp_addr(in AW), wp_hit(out 1, sticky);
//    a CPU write to wp_addr with wp_en while RUN commits, sets wp_hit, next state HALTED
//    (cpu_ce=0 next cycle); wp_hit clears on reset or when halt_req falls.
//    halt_req must be held 1 until host clears.
//  Not defined: no watchpoint ports/logic; behaviour otherwise identical.
// STRUCTURE
//  Package mcpu_pkg: state enum {RUN,HOST,HALTED,STEP}, MCPU_AW=6, MCPU_DW=8.
//  Sub-module mcpu_ram: 2**AW x DW register array, one write port, two async read ports
//    (CPU, host); write mux selected in mcpu_mem_ctrl.
// TESTING
//  Reset, host write 0x3F->addr 5, host read addr 5 -> ack 1 cycle, host_rdata=0x3F, halted=1.
//  Load program, release halt_req -> cpu_ce=1 next cycle; CPU write 0xA5 to 0x20 -> RAM[0x20]=0xA5.
//  host_req during RUN at edge n -> cpu_ce=0 at n+1, ack at n+1, cpu_ce=1 at n+2, stall_cnt=1.
//  Halted, step pulse -> exactly one cpu_ce=1 cycle; step+host_req same cycle -> HOST first.
//  host_req and halt_req rise together in RUN -> HOST, ack, then HALTED, halted=1.
//  MCPU_WATCHPOINT_EN: wp_addr=0x10, CPU writes 0x10 -> wp_hit=1, cpu_ce=0 next cycle.

Source files
------------

// File: rtl/mcpu_pkg.sv
// Shared types and default widths for the minimal-CPU memory controller slice.
package mcpu_pkg;

    localparam int unsigned MCPU_AW    = 6;
    localparam int unsigned MCPU_DW    = 8;
    localparam int unsigned MCPU_CNT_W = 16;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HOST   = 2'd1,
        HALTED = 2'd2,
        STEP   = 2'd3
    } mcpu_state_e;

endpackage

// File: rtl/mcpu_ram.sv
// Program/data RAM: 2**AW x DW register array, one write port, async CPU and host read ports.
module mcpu_ram
    import mcpu_pkg::*;
#(
    parameter int unsigned AW = MCPU_AW,
    parameter int unsigned DW = MCPU_DW
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] cpu_raddr_i,
    output logic [DW-1:0] cpu_rdata_c_o,
    input  logic [AW-1:0] host_raddr_i,
    output logic [DW-1:0] host_rdata_c_o
);

    localparam int unsigned DEPTH = 2 ** AW;

    logic [DW-1:0] mem_q [DEPTH];

    // Contents are deliberately never reset so a loaded program survives a CPU reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign cpu_rdata_c_o  = mem_q[cpu_raddr_i];
    assign host_rdata_c_o = mem_q[host_raddr_i];

endmodule

// File: rtl/mcpu_mem_ctrl.sv
// RAM owner/arbiter for the minimal CPU: host port access, halt/step/run control via cpu_ce.
// Optional watchpoint (halt on CPU write to wp_addr) enabled by defining MCPU_WATCHPOINT_EN.
module mcpu_mem_ctrl
    import mcpu_pkg::*;
#(
    parameter int unsigned AW    = MCPU_AW,
    parameter int unsigned DW    = MCPU_DW,
    parameter int unsigned CNT_W = MCPU_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AW-1:0]    cpu_addr,
    input  logic [DW-1:0]    cpu_wdata,
    input  logic             cpu_rd,
    input  logic             cpu_wr,
    output logic [DW-1:0]    cpu_rdata,
    output logic             cpu_ce,
    input  logic             host_req,
    input  logic             host_we,
    input  logic [AW-1:0]    host_addr,
    input  logic [DW-1:0]    host_wdata,
    output logic [DW-1:0]    host_rdata,
    output logic             host_ack,
    input  logic             halt_req,
    input  logic             step,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt
`ifdef MCPU_WATCHPOINT_EN
    ,
    input  logic             wp_en,
    input  logic [AW-1:0]    wp_addr,
    output logic             wp_hit
`endif
);

    mcpu_state_e      state_q, state_d;
    logic             cpu_ce_q, cpu_ce_d;
    logic             host_ack_q, host_ack_d;
    logic             halted_q, halted_d;
    logic [DW-1:0]    host_rdata_q, host_rdata_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             from_run_q, from_run_d;
    logic             req_blk_q, req_blk_d;
    logic             hwe_q, hwe_d;
    logic [AW-1:0]    haddr_q, haddr_d;
    logic [DW-1:0]    hwdata_q, hwdata_d;

    logic             cpu_we_c, host_we_c, host_req_v_c;
    logic             wp_trig_c, wp_hold_c;
    logic             ram_we_c;
    logic [AW-1:0]    ram_waddr_c;
    logic [DW-1:0]    ram_wdata_c;
    logic [DW-1:0]    ram_host_rdata_c;

    // The read strobe is informational only: the CPU read port is always live.
    logic unused_cpu_rd;
    assign unused_cpu_rd = cpu_rd;

    assign cpu_we_c     = cpu_wr & cpu_ce_q;
    // Host write lands at the end of the single HOST cycle; a reset in that cycle drops it.
    assign host_we_c    = (state_q == HOST) & hwe_q & rst;
    // A request still held after its ack is not a new request until it has been dropped.
    assign host_req_v_c = host_req & ~req_blk_q;

    assign ram_we_c    = cpu_we_c | host_we_c;
    assign ram_waddr_c = host_we_c ? haddr_q  : cpu_addr;
    assign ram_wdata_c = host_we_c ? hwdata_q : cpu_wdata;

    mcpu_ram #(
        .AW (AW),
        .DW (DW)
    ) u_ram (
        .clk            (clk),
        .we_i           (ram_we_c),
        .waddr_i        (ram_waddr_c),
        .wdata_i        (ram_wdata_c),
        .cpu_raddr_i    (cpu_addr),
        .cpu_rdata_c_o  (cpu_rdata),
        .host_raddr_i   (host_addr),
        .host_rdata_c_o (ram_host_rdata_c)
    );

`ifdef MCPU_WATCHPOINT_EN
    logic wp_hit_q;
    logic halt_req_q;

    assign wp_trig_c = (state_q == RUN) & cpu_we_c & wp_en & (cpu_addr == wp_addr);
    assign wp_hold_c = wp_hit_q;
    assign wp_hit    = wp_hit_q;

    // Sticky hit flag, cleared when the host releases halt_req.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wp_hit_q   <= 1'b0;
            halt_req_q <= 1'b0;
        end else begin
            halt_req_q <= halt_req;
            if (wp_trig_c) begin
                wp_hit_q <= 1'b1;
            end else if (halt_req_q & ~halt_req) begin
                wp_hit_q <= 1'b0;
            end
        end
    end
`else
    assign wp_trig_c = 1'b0;
    assign wp_hold_c = 1'b0;
`endif

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        from_run_d   = from_run_q;
        hwe_d        = hwe_q;
        haddr_d      = haddr_q;
        hwdata_d     = hwdata_q;
        host_rdata_d = host_rdata_q;
        host_ack_d   = 1'b0;
        stall_cnt_d  = stall_cnt_q;

        unique case (state_q)
            RUN: begin
                // A watchpoint hit must freeze the CPU even if the host asks at the same time.
                if (wp_trig_c) begin
                    state_d = HALTED;
                end else if (host_req_v_c) begin
                    state_d = HOST;
                end else if (halt_req) begin
                    state_d = HALTED;
                end
            end
            HOST: begin
                if (from_run_q && (stall_cnt_q != {CNT_W{1'b1}})) begin
                    stall_cnt_d = stall_cnt_q + CNT_W'(1);
                end
                state_d = (from_run_q && !halt_req) ? RUN : HALTED;
            end
            HALTED: begin
                if (host_req_v_c) begin
                    state_d = HOST;
                end else if (!halt_req && !wp_hold_c) begin
                    state_d = RUN;
                end else if (step) begin
                    state_d = STEP;
                end
            end
            STEP: begin
                state_d = HALTED;
            end
            default: begin
                state_d = HALTED;
            end
        endcase

        // Host access is captured on entry; read data bypasses a CPU write landing on the same edge.
        if ((state_d == HOST) && (state_q != HOST)) begin
            host_ack_d = 1'b1;
            from_run_d = (state_q == RUN);
            hwe_d      = host_we;
            haddr_d    = host_addr;
            hwdata_d   = host_wdata;
            if (!host_we) begin
                host_rdata_d = (cpu_we_c && (cpu_addr == host_addr)) ? cpu_wdata : ram_host_rdata_c;
            end
        end

        cpu_ce_d  = (state_d == RUN) || (state_d == STEP);
        halted_d  = (state_d == HALTED);
        req_blk_d = host_ack_d | (req_blk_q & host_req);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= HALTED;
            cpu_ce_q     <= 1'b0;
            host_ack_q   <= 1'b0;
            halted_q     <= 1'b1;
            host_rdata_q <= '0;
            stall_cnt_q  <= '0;
            from_run_q   <= 1'b0;
            req_blk_q    <= 1'b0;
            hwe_q        <= 1'b0;
            haddr_q      <= '0;
            hwdata_q     <= '0;
        end else begin
            state_q      <= state_d;
            cpu_ce_q     <= cpu_ce_d;
            host_ack_q   <= host_ack_d;
            halted_q     <= halted_d;
            host_rdata_q <= host_rdata_d;
            stall_cnt_q  <= stall_cnt_d;
            from_run_q   <= from_run_d;
            req_blk_q    <= req_blk_d;
            hwe_q        <= hwe_d;
            haddr_q      <= haddr_d;
            hwdata_q     <= hwdata_d;
        end
    end

    assign cpu_ce     = cpu_ce_q;
    assign host_ack   = host_ack_q;
    assign halted     = halted_q;
    assign host_rdata = host_rdata_q;
    assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_mcpu_mem_ctrl.sv
// Self-checking bench for mcpu_mem_ctrl: vector table, directed corner sequences, random traffic vs memory model.
module tb_mcpu_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_rd;
    logic        cpu_wr;
    logic [7:0]  cpu_rdata;
    logic        cpu_ce;
    logic        host_req;
    logic        host_we;
    logic [5:0]  host_addr;
    logic [7:0]  host_wdata;
    logic [7:0]  host_rdata;
    logic        host_ack;
    logic        halt_req;
    logic        step;
    logic        halted;
    logic [15:0] stall_cnt;
`ifdef MCPU_WATCHPOINT_EN
    logic        wp_en;
    logic [5:0]  wp_addr;
    logic        wp_hit;
`endif

    mcpu_mem_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rd     (cpu_rd),
        .cpu_wr     (cpu_wr),
        .cpu_rdata  (cpu_rdata),
        .cpu_ce     (cpu_ce),
        .host_req   (host_req),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_rdata (host_rdata),
        .host_ack   (host_ack),
        .halt_req   (halt_req),
        .step       (step),
        .halted     (halted),
        .stall_cnt  (stall_cnt)
`ifdef MCPU_WATCHPOINT_EN
        ,
        .wp_en      (wp_en),
        .wp_addr    (wp_addr),
        .wp_hit     (wp_hit)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic       we;
        logic [5:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rdata;
    } hvec_t;

    hvec_t      tbl [9];
    logic [7:0] mem [64];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Bounded host access: returns read data seen with the ack; drops req after ack.
    task automatic host_access(input logic we, input logic [5:0] a, input logic [7:0] d,
                               output logic [7:0] rd);
        bit ok;
        ok = 1'b0;
        rd = 8'h00;
        host_req = 1'b1; host_we = we; host_addr = a; host_wdata = d;
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (host_ack) begin
                ok = 1'b1;
                rd = host_rdata;
                break;
            end
        end
        host_req = 1'b0;
        chk("host_ack_seen", 32'(ok), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rd;
        int         cnt;
        int         acks;
        bit         req_pend, r_we, hw_pend, cw_pend, ack_now;
        int         req_age;
        logic [5:0] r_addr, hw_a, cw_a;
        logic [7:0] hw_d, cw_d;

        tbl[0] = '{1'b1, 6'd5,  8'h3F, 8'h00};
        tbl[1] = '{1'b0, 6'd5,  8'h00, 8'h3F};
        tbl[2] = '{1'b1, 6'd0,  8'h11, 8'h00};
        tbl[3] = '{1'b1, 6'd63, 8'hC3, 8'h00};
        tbl[4] = '{1'b0, 6'd0,  8'h00, 8'h11};
        tbl[5] = '{1'b0, 6'd63, 8'h00, 8'hC3};
        tbl[6] = '{1'b1, 6'd5,  8'h00, 8'h00};
        tbl[7] = '{1'b0, 6'd5,  8'h00, 8'h00};
        tbl[8] = '{1'b0, 6'd63, 8'h00, 8'hC3};

        rst = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_rd = 1'b0; cpu_wr = 1'b0;
        host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
        halt_req = 1'b1; step = 1'b0;
`ifdef MCPU_WATCHPOINT_EN
        wp_en = 1'b0; wp_addr = '0;
`endif
        cyc(); cyc();
        chk("rst_cpu_ce", 32'(cpu_ce), 32'd0);
        chk("rst_host_ack", 32'(host_ack), 32'd0);
        chk("rst_host_rdata", 32'(host_rdata), 32'd0);
        chk("rst_halted", 32'(halted), 32'd1);
        chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        rst = 1'b1;
        cyc();

        // Host loader vectors while halted.
        for (int i = 0; i < 9; i++) begin
            host_access(tbl[i].we, tbl[i].addr, tbl[i].wdata, rd);
            if (!tbl[i].we) chk($sformatf("tbl%0d_rdata", i), 32'(rd), 32'(tbl[i].exp_rdata));
            chk($sformatf("tbl%0d_ce_in_host", i), 32'(cpu_ce), 32'd0);
            cyc();
            chk($sformatf("tbl%0d_ack_one_cycle", i), 32'(host_ack), 32'd0);
            chk($sformatf("tbl%0d_halted", i), 32'(halted), 32'd1);
        end

        // Step held two cycles still yields exactly one enabled CPU cycle.
        cnt = 0;
        step = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            if (cpu_ce) cnt++;
            if (i == 1) step = 1'b0;
        end
        chk("step_one_ce_cycle", 32'(cnt), 32'd1);
        chk("step_back_halted", 32'(halted), 32'd1);

        // step and host_req together: host wins.
        step = 1'b1; host_req = 1'b1; host_we = 1'b0; host_addr = 6'd0;
        cyc();
        chk("step_host_ack", 32'(host_ack), 32'd1);
        chk("step_host_ce", 32'(cpu_ce), 32'd0);
        chk("step_host_rdata", 32'(host_rdata), 32'h11);
        step = 1'b0; host_req = 1'b0;
        cyc();
        chk("step_host_ret_halted", 32'(halted), 32'd1);
        chk("step_host_ret_ce", 32'(cpu_ce), 32'd0);

        // A request held past its ack is served only once.
        cnt = 0;
        host_req = 1'b1; host_addr = 6'd63;
        for (int i = 0; i < 5; i++) begin
            cyc();
            if (host_ack) cnt++;
        end
        chk("held_req_single_ack", 32'(cnt), 32'd1);
        host_req = 1'b0;
        cyc();

        // Reset on the accepting edge aborts the write and issues no ack.
        host_access(1'b1, 6'd9, 8'h12, rd);
        cyc();
        rst = 1'b0; host_req = 1'b1; host_we = 1'b1; host_addr = 6'd9; host_wdata = 8'h77;
        cyc();
        chk("rst_mid_no_ack", 32'(host_ack), 32'd0);
        rst = 1'b1; host_req = 1'b0;
        cyc();
        host_access(1'b0, 6'd9, 8'h00, rd);
        chk("rst_mid_ram_kept", 32'(rd), 32'h12);
        cyc();

        // Release halt: CPU runs next cycle and writes.
        halt_req = 1'b0;
        cyc();
        chk("run_ce", 32'(cpu_ce), 32'd1);
        chk("run_halted", 32'(halted), 32'd0);
        cpu_addr = 6'h20; cpu_wdata = 8'hA5; cpu_wr = 1'b1;
        cyc();
        cpu_wr = 1'b0;
        chk("cpu_write_rdata", 32'(cpu_rdata), 32'hA5);

        // Host read during RUN: one stalled cycle.
        host_req = 1'b1; host_we = 1'b0; host_addr = 6'h20;
        cyc();
        chk("run_host_ce_off", 32'(cpu_ce), 32'd0);
        chk("run_host_ack", 32'(host_ack), 32'd1);
        chk("run_host_rdata", 32'(host_rdata), 32'hA5);
        host_req = 1'b0;
        cyc();
        chk("run_host_ce_back", 32'(cpu_ce), 32'd1);
        chk("run_host_ack_low", 32'(host_ack), 32'd0);
        chk("run_host_stall1", 32'(stall_cnt), 32'd1);

        // host_req and halt_req together from RUN.
        host_req = 1'b1; halt_req = 1'b1;
        cyc();
        chk("both_ack", 32'(host_ack), 32'd1);
        chk("both_ce", 32'(cpu_ce), 32'd0);
        host_req = 1'b0;
        cyc();
        chk("both_halted", 32'(halted), 32'd1);
        chk("both_ce_after", 32'(cpu_ce), 32'd0);
        chk("both_stall2", 32'(stall_cnt), 32'd2);

        // Known RAM image for the random phase.
        for (int a = 0; a < 64; a++) begin
            mem[a] = 8'($urandom);
            host_access(1'b1, 6'(a), mem[a], rd);
            cyc();
        end

        // Random CPU/host traffic while running, checked against a flat memory model.
        halt_req = 1'b0;
        cyc();
        acks = 0; req_pend = 0; hw_pend = 0; cw_pend = 0; req_age = 0;
        r_we = 0; r_addr = '0; hw_a = '0; hw_d = '0; cw_a = '0; cw_d = '0;
        for (int k = 0; k < 600; k++) begin
            if (hw_pend) begin mem[hw_a] = hw_d; hw_pend = 0; end
            if (cw_pend) begin mem[cw_a] = cw_d; cw_pend = 0; end
            chk("rnd_ce_vs_ack", 32'(cpu_ce), 32'(!host_ack));
            ack_now = host_ack;
            if (req_pend) begin
                if (host_ack) begin
                    if (!r_we) chk("rnd_host_rdata", 32'(host_rdata), 32'(mem[r_addr]));
                    else begin hw_pend = 1; hw_a = r_addr; hw_d = host_wdata; end
                    acks++; req_pend = 0; host_req = 1'b0;
                end else if (req_age >= 3) begin
                    chk("rnd_ack_timeout", 32'(host_ack), 32'd1);
                    req_pend = 0; host_req = 1'b0;
                end else begin
                    req_age++;
                end
            end else begin
                chk("rnd_no_spurious_ack", 32'(host_ack), 32'd0);
            end
            cpu_addr = 6'($urandom); cpu_wdata = 8'($urandom);
            cpu_wr = ($urandom_range(0, 2) == 0);
            if (cpu_wr && cpu_ce) begin cw_pend = 1; cw_a = cpu_addr; cw_d = cpu_wdata; end
            if (!req_pend && !ack_now && ($urandom_range(0, 4) == 0)) begin
                r_we = $urandom_range(0, 1); r_addr = 6'($urandom);
                host_we = r_we; host_addr = r_addr; host_wdata = 8'($urandom);
                host_req = 1'b1; req_pend = 1; req_age = 0;
            end
            #1;
            chk("rnd_cpu_rdata", 32'(cpu_rdata), 32'(mem[cpu_addr]));
            cyc();
        end
        cpu_wr = 1'b0;
        if (req_pend) begin
            if (host_ack) acks++;
            host_req = 1'b0;
        end
        cyc(); cyc();
        chk("rnd_stall_cnt", 32'(stall_cnt), 32'(2 + acks));

`ifdef MCPU_WATCHPOINT_EN
        wp_en = 1'b1; wp_addr = 6'h10;
        cpu_addr = 6'h10; cpu_wdata = 8'h5A; cpu_wr = 1'b1;
        cyc();
        cpu_wr = 1'b0; wp_en = 1'b0;
        chk("wp_hit", 32'(wp_hit), 32'd1);
        chk("wp_ce_off", 32'(cpu_ce), 32'd0);
        chk("wp_write_committed", 32'(cpu_rdata), 32'h5A);
        cyc();
        chk("wp_stays_halted", 32'(halted), 32'd1);
        halt_req = 1'b1; cyc();
        halt_req = 1'b0; cyc();
        chk("wp_cleared", 32'(wp_hit), 32'd0);
        cyc();
        chk("wp_resumed", 32'(cpu_ce), 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
